fft_agu: RTL
============

// Module: fft_agu
// PURPOSE
// - Address-generation/sequencing unit driving the read side of fft_pipe and qualifying its write side.
// - On i_start, walks all log2(N) radix-2 stages of an in-place N-point FFT, issuing one butterfly read pair (A,B) per cycle.
// - Produces the RAM write enable matched to the pipe latency.
// - Inserts a drain gap between stages so stage s+1 never reads a word before stage s has written it back.
// - Input data is already in bit-reversed order in the dual-port RAM; no twiddles are applied (o_stage is exported for later use).
// PARAMETERS
// - ADDR_SIZE  5  log2(N); N = 2**ADDR_SIZE points; legal range >= 2
// - PIPE_LAT   3  cycles from o_rden/o_rdaddr_* to the matching fft_pipe o_wraddr_*/o_wrdata_* (1 RAM read + 2 pipe regs); >= 1
// - STAGE_W    $clog2(ADDR_SIZE)  width of the stage index (derived, not overridden)
// PORTS
// - i_CLK       in   1          clock, rising edge
// - i_RST       in   1          asynchronous, active-low reset
// - i_start     in   1          begin a transform; sampled only in IDLE
// - o_busy      out  1          high in ISSUE and DRAIN
// - o_done      out  1          one-cycle pulse after the last write-back of the last stage
// - o_rden      out  1          read pair valid this cycle
// - o_rdaddr_A  out  ADDR_SIZE  butterfly top address (feeds RAM port A and fft_pipe i_rdaddr_A)
// - o_rdaddr_B  out  ADDR_SIZE  butterfly bottom address (port B / i_rdaddr_B)
// - o_wren      out  1          write-back strobe for both RAM ports; o_rden delayed by PIPE_LAT
// - o_stage     out  STAGE_W    current stage index, 0..ADDR_SIZE-1
// BEHAVIOUR
// - Reset (i_RST=0, async): state=IDLE; all outputs 0; all counters 0; wren shift register cleared.
//   A transform in flight is discarded; no write strobe may follow reset release.
// - FSM states: IDLE, ISSUE, DRAIN, DONE.
//   - IDLE -> ISSUE when i_start=1. k=0, s=0.
//   - ISSUE: o_rden=1 every cycle; k increments.
//     When k = 2**(ADDR_SIZE-1)-1, go to DRAIN; k wraps to 0.
//   - DRAIN: o_rden=0 for exactly PIPE_LAT cycles (drain counter).
//     On the last drain cycle: if s = ADDR_SIZE-1, go to DONE; else s+1 and go to ISSUE.
//   - DONE: o_done=1 for one cycle, then IDLE.
// - Address math, with span = 2**s, group = k>>s, pos = k & (span-1):
//   - A = (group << (s+1)) | pos
//   - B = A | span
//   - All math is ADDR_SIZE wide, with no carries out.
// - o_rdaddr_*, o_rden and o_stage are registered: they change only on the clock edge that enters or advances ISSUE.
// - o_wren is bit PIPE_LAT-1 of a shift register fed by o_rden. It is independent of FSM state.
// - Hazard rule:
//   - The last write of a stage strobes in the final DRAIN cycle.
//   - The first read of the next stage is issued the cycle after.
//   - The RAM write-before-read ordering across the edge must hold.
// - Cycle budget: busy = ADDR_SIZE*(2**(ADDR_SIZE-1)+PIPE_LAT) cycles, then 1 DONE cycle.
// - i_start while busy or in DONE: ignored (no restart, no queueing).
// - i_start held high: a new transform starts on the cycle after DONE returns to IDLE.
// STRUCTURE
// - Shared package fft_pkg holds:
//   - FSM state encoding localparams (S_IDLE..S_DONE)
//   - a constant function for the butterfly address pair, reused by the twiddle ROM indexer
//   - default ADDR_SIZE/PIPE_LAT values
// - One sub-module, valid_delay (parameterised DEPTH, async active-low reset), provides the o_rden -> o_wren shift register.
//   fft_pipe integration reuses it.
// - FSM, butterfly counter, stage counter and drain counter stay in fft_agu.
// TESTING
// - Use ADDR_SIZE=3, PIPE_LAT=3 unless noted.
// 1. Start pulse -> the o_rdaddr_A/B sequence must be:
//    - s0: (0,1)(2,3)(4,5)(6,7)
//    - s1: (0,2)(1,3)(4,6)(5,7)
//    - s2: (0,4)(1,5)(2,6)(3,7)
//    Each stage has 4 o_rden cycles followed by 3 idle cycles.
// 2. Timing check:
//    - o_busy high for exactly 21 cycles.
//    - o_done high 1 cycle immediately after.
//    - o_wren equals o_rden delayed 3 cycles, 12 strobes in total.
//    - The last strobe of each stage is in the cycle just before the next stage's first o_rden.
// 3. i_start pulsed again mid-ISSUE and mid-DRAIN -> the address sequence is unchanged, and there is one o_done only.
// 4. i_RST asserted low in stage 1 while o_wren is pending -> outputs are 0 asynchronously. After release: no o_wren, IDLE, o_stage=0.
// 5. Attach an fft_pipe + RAM model loaded with x[n]=1 (bit-reversed) -> bin 0 = 8 after o_done; all other bins 0.
//    Repeat with ADDR_SIZE=5, PIPE_LAT=1: 16 pairs per stage, busy = 85 cycles.
// 6. i_start held high continuously -> back-to-back transforms separated by exactly 1 IDLE cycle after each DONE.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package   : fft_pkg
// Purpose   : Shared FFT definitions: AGU state encoding, default sizing and
//             the radix-2 butterfly address helpers.
// Revision  : 1.0  initial release
// ============================================================================
package fft_pkg;

    // Default transform size (log2 N) and read-to-write-back latency
    localparam int DEF_ADDR_SIZE = 5;
    localparam int DEF_PIPE_LAT  = 3;

    // Address generator sequencing states
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } agu_state_t;

    // Top address of butterfly k in stage s: the group index is shifted past
    // the span bit, and the position within the group fills the low bits.
    function automatic logic [31:0] bfly_a(input logic [31:0] stage,
                                           input logic [31:0] k);
        logic [31:0] span;
        logic [31:0] group;
        logic [31:0] pos;
        span  = 32'd1 << stage;
        group = k >> stage;
        pos   = k & (span - 32'd1);
        return (group << (stage + 32'd1)) | pos;
    endfunction

    // Bottom address: the top address with the span bit set.
    function automatic logic [31:0] bfly_b(input logic [31:0] stage,
                                           input logic [31:0] k);
        return bfly_a(stage, k) | (32'd1 << stage);
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/valid_delay.sv
`default_nettype none
// ============================================================================
// Module    : valid_delay
// Purpose   : DEPTH-cycle delay line for a single valid strobe, cleared by
//             the asynchronous active-low reset so no stale strobe survives.
// Revision  : 1.0  initial release
// ============================================================================
module valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    if (DEPTH == 1) begin : g_single
        // A one-deep line is just the registered input
        always_comb shift_d = i_valid;
    end else begin : g_multi
        // Shift the new strobe in at bit 0; the oldest leaves at the top
        always_comb shift_d = {shift_q[DEPTH-2:0], i_valid};
    end

    // Delay-line register, flushed on reset
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign o_valid = shift_q[DEPTH-1];

endmodule : valid_delay
`default_nettype wire

// File: rtl/fft_agu.sv
`default_nettype none
// ============================================================================
// Module    : fft_agu
// Purpose   : Address generator for an in-place radix-2 FFT. Walks every
//             stage issuing one butterfly read pair per cycle, leaves a
//             PIPE_LAT-cycle drain gap between stages, and produces the
//             write-back strobe aligned to the butterfly pipe latency.
// Revision  : 1.0  initial release
// ============================================================================
module fft_agu
    import fft_pkg::*;
#(
    parameter  int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter  int PIPE_LAT  = DEF_PIPE_LAT,
    localparam int STAGE_W   = $clog2(ADDR_SIZE)
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rden,
    output logic [ADDR_SIZE-1:0] o_rdaddr_A,
    output logic [ADDR_SIZE-1:0] o_rdaddr_B,
    output logic                 o_wren,
    output logic [STAGE_W-1:0]   o_stage
);

    // Butterfly index width: N/2 butterflies per stage
    localparam int K_W     = ADDR_SIZE - 1;
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [K_W-1:0]     c_K_LAST     = {K_W{1'b1}};
    localparam logic [STAGE_W-1:0] c_STAGE_LAST = STAGE_W'(ADDR_SIZE - 1);
    localparam logic [DRAIN_W-1:0] c_DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    agu_state_t           state_q,  state_d;
    logic [K_W-1:0]       k_q,      k_d;
    logic [DRAIN_W-1:0]   drain_q,  drain_d;
    logic [STAGE_W-1:0]   stage_q,  stage_d;
    logic [ADDR_SIZE-1:0] addr_a_q, addr_a_d;
    logic [ADDR_SIZE-1:0] addr_b_q, addr_b_d;
    logic                 busy_q,   busy_d;
    logic                 rden_q,   rden_d;
    logic                 done_q,   done_d;

    logic                 w_load_addr;
    logic [STAGE_W-1:0]   w_stage_sel;
    logic [K_W-1:0]       w_k_sel;

    // Next-state, counter and address sequencing
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        drain_d     = drain_q;
        stage_d     = stage_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        w_load_addr = 1'b0;
        w_stage_sel = stage_q;
        w_k_sel     = k_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d     = S_ISSUE;
                    k_d         = '0;
                    stage_d     = '0;
                    drain_d     = '0;
                    w_load_addr = 1'b1;
                    w_stage_sel = '0;
                    w_k_sel     = '0;
                end
            end
            S_ISSUE: begin
                if (k_q == c_K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                    drain_d = '0;
                end else begin
                    k_d         = k_q + K_W'(1);
                    w_load_addr = 1'b1;
                    w_k_sel     = k_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == c_DRAIN_LAST) begin
                    drain_d = '0;
                    if (stage_q == c_STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_ISSUE;
                        stage_d     = stage_q + STAGE_W'(1);
                        w_load_addr = 1'b1;
                        w_stage_sel = stage_q + STAGE_W'(1);
                        w_k_sel     = '0;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Addresses only move when a new butterfly is issued
        if (w_load_addr) begin
            addr_a_d = ADDR_SIZE'(bfly_a(32'(w_stage_sel), 32'(w_k_sel)));
            addr_b_d = ADDR_SIZE'(bfly_b(32'(w_stage_sel), 32'(w_k_sel)));
        end

        // Status outputs are registered from the upcoming state
        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        rden_d = (state_d == S_ISSUE);
        done_d = (state_d == S_DONE);
    end

    // Sequencer registers; reset discards any transform in flight
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            drain_q  <= '0;
            stage_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            busy_q   <= 1'b0;
            rden_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            drain_q  <= drain_d;
            stage_q  <= stage_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            busy_q   <= busy_d;
            rden_q   <= rden_d;
            done_q   <= done_d;
        end
    end

    // Write-back strobe: the read strobe delayed by the pipe latency
    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_wren_dly (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_valid (rden_q),
        .o_valid (o_wren)
    );

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rden     = rden_q;
    assign o_rdaddr_A = addr_a_q;
    assign o_rdaddr_B = addr_b_q;
    assign o_stage    = stage_q;

endmodule : fft_agu
`default_nettype wire
